// File: rtl/disparo_alarme_pkg.sv
// ---------------------------------------------------------------------------
// disparo_alarme_pkg
//   Shared definitions for the alarm clock datapath: FSM state encoding of the
//   alarm reader, BCD field widths and the 24-bit {HH,MM,SS} time packing.
//   Also imported by the clock counter chain and the alarm setter, so any change
//   here affects all three blocks.
// ---------------------------------------------------------------------------
package disparo_alarme_pkg;

  // One BCD digit is 4 bits; a time word holds six digits {Ht,Hu,Mt,Mu,St,Su}.
  localparam int BCD_W   = 4;
  localparam int DIGITOS = 6;
  localparam int CAMPO_W = 2 * BCD_W;        // one field (HH, MM or SS)
  localparam int TEMPO_W = BCD_W * DIGITOS;  // full packed time word

  // Bit offsets of each field inside the packed time word.
  localparam int POS_HH = 2 * CAMPO_W;
  localparam int POS_MM = CAMPO_W;
  localparam int POS_SS = 0;

  // Alarm reader states; the encoding is visible on the estado output.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TOCANDO = 2'd1,
    SONECA  = 2'd2
  } estado_t;

  // Packs three two-digit BCD fields into a time word, hour tens at the MSB.
  function automatic logic [TEMPO_W-1:0] empacotar_tempo(
    input logic [CAMPO_W-1:0] hh,
    input logic [CAMPO_W-1:0] mm,
    input logic [CAMPO_W-1:0] ss
  );
    logic [TEMPO_W-1:0] w;
    w = '0;
    w[POS_HH +: CAMPO_W] = hh;
    w[POS_MM +: CAMPO_W] = mm;
    w[POS_SS +: CAMPO_W] = ss;
    return w;
  endfunction

endpackage

// File: rtl/detector_borda.sv
// ---------------------------------------------------------------------------
// detector_borda
//   Rising-edge detector: registers the input and emits a one-cycle pulse on
//   the cycle where the input is high and was low on the previous cycle.
//   A level held high produces only one pulse.
// Ports
//   i_clk    in  1  clock
//   i_rst    in  1  synchronous active-high reset (previous sample cleared)
//   i_sinal  in  1  level to watch, synchronous to i_clk
//   o_pulso  out 1  combinational pulse: i_sinal & ~previous sample
// ---------------------------------------------------------------------------
module detector_borda (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sinal,
  output logic o_pulso
);

  logic r_anterior;

  // NOTE: clocked state is updated with non-blocking assignments so every
  // register samples the values from before the edge, independent of the
  // order in which the always blocks are evaluated.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_anterior <= 1'b0;
    end else begin
      r_anterior <= i_sinal;
    end
  end

  assign o_pulso = i_sinal & ~r_anterior;

endmodule

// File: rtl/disparo_alarme.sv
// ---------------------------------------------------------------------------
// disparo_alarme
//   Reader side of the alarm register. Compares the running clock time with
//   the alarm time, starts ringing on the first cycle of a match, and handles
//   snooze and stop. Ringing lasts TEMPO_TOQUE ticks, each snooze silences for
//   TEMPO_SONECA ticks, and at most MAX_SONECAS snoozes are granted per event.
// Parameters
//   TEMPO_TOQUE   seconds of ringing before automatic stop
//   TEMPO_SONECA  seconds of silence per snooze
//   MAX_SONECAS   snoozes allowed per alarm event (must fit in 2 bits)
//   LARGURA_CNT   width of the seconds down-counter
// Ports
//   clk50mhz         in  1   board clock
//   resetar          in  1   synchronous active-high reset
//   tick_1hz         in  1   one-cycle pulse per second
//   hora_atual       in  24  current time, packed BCD {HH,MM,SS}
//   alarme_completo  in  24  alarm time, same packing
//   alarme_ativo     in  1   1 = alarm armed; 0 forces IDLE
//   btn_soneca       in  1   snooze button level (debounced)
//   btn_parar        in  1   stop button level (debounced)
//   buzzer           out 1   1 s on / 1 s off while ringing (registered)
//   led_alarme       out 1   high in TOCANDO or SONECA (registered)
//   estado           out 2   current FSM state
//   sonecas_usadas   out 2   snoozes consumed in the current event
// ---------------------------------------------------------------------------
module disparo_alarme
  import disparo_alarme_pkg::*;
#(
  parameter int TEMPO_TOQUE  = 60,
  parameter int TEMPO_SONECA = 300,
  parameter int MAX_SONECAS  = 3,
  parameter int LARGURA_CNT  = 9
) (
  input  logic               clk50mhz,
  input  logic               resetar,
  input  logic               tick_1hz,
  input  logic [TEMPO_W-1:0] hora_atual,
  input  logic [TEMPO_W-1:0] alarme_completo,
  input  logic               alarme_ativo,
  input  logic               btn_soneca,
  input  logic               btn_parar,
  output logic               buzzer,
  output logic               led_alarme,
  output logic [1:0]         estado,
  output logic [1:0]         sonecas_usadas
);

  localparam logic [LARGURA_CNT-1:0] CNT_TOQUE  = LARGURA_CNT'(TEMPO_TOQUE);
  localparam logic [LARGURA_CNT-1:0] CNT_SONECA = LARGURA_CNT'(TEMPO_SONECA);
  localparam logic [LARGURA_CNT-1:0] CNT_UM     = LARGURA_CNT'(1);
  localparam logic [1:0]             LIM_SONECA = 2'(MAX_SONECAS);

  // -------------------------------------------------------------------------
  // Registers and next-state wires
  // -------------------------------------------------------------------------
  estado_t                r_estado;
  logic [LARGURA_CNT-1:0] r_cnt;
  logic                   r_fase;     // buzzer phase: 1 = sounding second
  logic [1:0]             r_sonecas;
  logic                   r_buzzer;
  logic                   r_led;

  estado_t                w_estado_prox;
  logic [LARGURA_CNT-1:0] w_cnt_prox;
  logic                   w_fase_prox;
  logic [1:0]             w_sonecas_prox;

  logic w_igual;
  logic w_pulso_igual;
  logic w_disparo;
  logic w_p_soneca;
  logic w_p_parar;
  logic w_expirou;

  // -------------------------------------------------------------------------
  // Match and button edge detection
  // -------------------------------------------------------------------------
  // Raw equality of the packed words; invalid BCD codes compare like any other
  // value. Only the first cycle of a match counts, so a match that lasts the
  // whole second raises a single event.
  assign w_igual = (hora_atual == alarme_completo);

  detector_borda u_borda_igual (
    .i_clk   (clk50mhz),
    .i_rst   (resetar),
    .i_sinal (w_igual),
    .o_pulso (w_pulso_igual)
  );

  detector_borda u_borda_soneca (
    .i_clk   (clk50mhz),
    .i_rst   (resetar),
    .i_sinal (btn_soneca),
    .o_pulso (w_p_soneca)
  );

  detector_borda u_borda_parar (
    .i_clk   (clk50mhz),
    .i_rst   (resetar),
    .i_sinal (btn_parar),
    .o_pulso (w_p_parar)
  );

  assign w_disparo = w_pulso_igual & alarme_ativo;

  // Last tick of a ringing or snooze period.
  assign w_expirou = tick_1hz & (r_cnt == CNT_UM);

  // -------------------------------------------------------------------------
  // State register, counters and registered outputs
  // -------------------------------------------------------------------------
  // NOTE: only control state is reset here; there is no storage array in this
  // block, so every register returns to a known value on resetar.
  always_ff @(posedge clk50mhz) begin
    if (resetar) begin
      r_estado  <= IDLE;
      r_cnt     <= '0;
      r_fase    <= 1'b0;
      r_sonecas <= 2'd0;
      r_buzzer  <= 1'b0;
      r_led     <= 1'b0;
    end else begin
      r_estado  <= w_estado_prox;
      r_cnt     <= w_cnt_prox;
      r_fase    <= w_fase_prox;
      r_sonecas <= w_sonecas_prox;
      // Outputs follow the registered state with one cycle of latency.
      r_buzzer  <= (r_estado == TOCANDO) & r_fase;
      r_led     <= (r_estado != IDLE);
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  //   Priority: ~alarme_ativo > p_parar > p_soneca > expiry > tick decrement.
  //   A granted snooze consumes the cycle, so a coincident tick is dropped.
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_estado_prox  = r_estado;
    w_cnt_prox     = r_cnt;
    w_fase_prox    = r_fase;
    w_sonecas_prox = r_sonecas;

    if (!alarme_ativo || w_p_parar) begin
      w_estado_prox = IDLE;
      w_cnt_prox    = '0;
      w_fase_prox   = 1'b0;
    end else begin
      unique case (r_estado)
        IDLE: begin
          if (w_disparo) begin
            w_estado_prox  = TOCANDO;
            w_cnt_prox     = CNT_TOQUE;
            w_fase_prox    = 1'b1;
            w_sonecas_prox = 2'd0;
          end
        end

        TOCANDO: begin
          // Snooze presses at the limit fall through and ringing continues.
          if (w_p_soneca && (r_sonecas < LIM_SONECA)) begin
            w_estado_prox  = SONECA;
            w_cnt_prox     = CNT_SONECA;
            w_sonecas_prox = r_sonecas + 2'd1;
          end else if (w_expirou) begin
            w_estado_prox = IDLE;
            w_cnt_prox    = '0;
            w_fase_prox   = 1'b0;
          end else if (tick_1hz) begin
            w_cnt_prox  = r_cnt - CNT_UM;
            w_fase_prox = ~r_fase;
          end
        end

        SONECA: begin
          // Snooze button has no effect while already snoozing.
          if (w_expirou) begin
            w_estado_prox = TOCANDO;
            w_cnt_prox    = CNT_TOQUE;
            w_fase_prox   = 1'b1;
          end else if (tick_1hz) begin
            w_cnt_prox = r_cnt - CNT_UM;
          end
        end

        default: begin
          w_estado_prox = IDLE;
          w_cnt_prox    = '0;
          w_fase_prox   = 1'b0;
        end
      endcase
    end
  end

  assign buzzer         = r_buzzer;
  assign led_alarme     = r_led;
  assign estado         = r_estado;
  assign sonecas_usadas = r_sonecas;

endmodule

// File: tb/tb_disparo_alarme.sv
// ---------------------------------------------------------------------------
// tb_disparo_alarme
//   Directed bench for disparo_alarme with short timings
//   (TEMPO_TOQUE=4, TEMPO_SONECA=3, MAX_SONECAS=2). Inputs change 1 ns after
//   a rising edge; outputs are read at that same point, reflecting that edge.
// ---------------------------------------------------------------------------
module tb_disparo_alarme;
  import disparo_alarme_pkg::*;

  logic               clk50mhz;
  logic               resetar;
  logic               tick_1hz;
  logic [TEMPO_W-1:0] hora_atual;
  logic [TEMPO_W-1:0] alarme_completo;
  logic               alarme_ativo;
  logic               btn_soneca;
  logic               btn_parar;
  logic               buzzer;
  logic               led_alarme;
  logic [1:0]         estado;
  logic [1:0]         sonecas_usadas;

  int n_pass  = 0;
  int n_total = 0;

  disparo_alarme #(
    .TEMPO_TOQUE  (4),
    .TEMPO_SONECA (3),
    .MAX_SONECAS  (2),
    .LARGURA_CNT  (9)
  ) dut (
    .clk50mhz        (clk50mhz),
    .resetar         (resetar),
    .tick_1hz        (tick_1hz),
    .hora_atual      (hora_atual),
    .alarme_completo (alarme_completo),
    .alarme_ativo    (alarme_ativo),
    .btn_soneca      (btn_soneca),
    .btn_parar       (btn_parar),
    .buzzer          (buzzer),
    .led_alarme      (led_alarme),
    .estado          (estado),
    .sonecas_usadas  (sonecas_usadas)
  );

  initial clk50mhz = 1'b0;
  always #10 clk50mhz = ~clk50mhz;

  // One clock edge, then settle 1 ns past it.
  task automatic ciclo();
    @(posedge clk50mhz);
    #1;
  endtask

  // One tick_1hz pulse seen by exactly one edge.
  task automatic pulso_tick();
    tick_1hz = 1'b1;
    ciclo();
    tick_1hz = 1'b0;
  endtask

  // Move off the alarm time, then onto it: the second edge raises the event.
  task automatic disparar();
    hora_atual = empacotar_tempo(8'h00, 8'h00, 8'h00);
    ciclo();
    hora_atual = alarme_completo;
    ciclo();
  endtask

  task automatic test_reset();
    resetar = 1'b1;
    ciclo();
    ciclo();
    resetar = 1'b0;
    n_total++; if (estado !== 2'd0) $display("FAIL rst_estado: got %0d want 0", estado); else n_pass++;
    n_total++; if (buzzer !== 1'b0) $display("FAIL rst_buzzer: got %b want 0", buzzer); else n_pass++;
    n_total++; if (led_alarme !== 1'b0) $display("FAIL rst_led: got %b want 0", led_alarme); else n_pass++;
    n_total++; if (sonecas_usadas !== 2'd0) $display("FAIL rst_sonecas: got %0d want 0", sonecas_usadas); else n_pass++;
  endtask

  task automatic test_disparo_basico();
    alarme_completo = empacotar_tempo(8'h07, 8'h00, 8'h00);
    hora_atual      = empacotar_tempo(8'h06, 8'h59, 8'h59);
    ciclo();
    n_total++; if (estado !== 2'd0) $display("FAIL t1_antes: got %0d want 0", estado); else n_pass++;
    hora_atual = empacotar_tempo(8'h07, 8'h00, 8'h00);
    ciclo();
    n_total++; if (estado !== 2'd1) $display("FAIL t1_estado: got %0d want 1", estado); else n_pass++;
    n_total++; if (buzzer !== 1'b0) $display("FAIL t1_buzzer_lat: got %b want 0", buzzer); else n_pass++;
    ciclo();
    n_total++; if (buzzer !== 1'b1) $display("FAIL t1_buzzer_on: got %b want 1", buzzer); else n_pass++;
    n_total++; if (led_alarme !== 1'b1) $display("FAIL t1_led_on: got %b want 1", led_alarme); else n_pass++;
    pulso_tick();
    ciclo();
    n_total++; if (buzzer !== 1'b0) $display("FAIL t1_buzzer_t1: got %b want 0", buzzer); else n_pass++;
    pulso_tick();
    ciclo();
    n_total++; if (buzzer !== 1'b1) $display("FAIL t1_buzzer_t2: got %b want 1", buzzer); else n_pass++;
    pulso_tick();
    n_total++; if (estado !== 2'd1) $display("FAIL t1_estado_t3: got %0d want 1", estado); else n_pass++;
    pulso_tick();
    n_total++; if (estado !== 2'd0) $display("FAIL t1_estado_t4: got %0d want 0", estado); else n_pass++;
    ciclo();
    n_total++; if (led_alarme !== 1'b0) $display("FAIL t1_led_off: got %b want 0", led_alarme); else n_pass++;
    n_total++; if (buzzer !== 1'b0) $display("FAIL t1_buzzer_off: got %b want 0", buzzer); else n_pass++;
  endtask

  task automatic test_inativo_e_unico();
    hora_atual = empacotar_tempo(8'h00, 8'h00, 8'h00);
    ciclo();
    alarme_ativo = 1'b0;
    hora_atual   = alarme_completo;
    ciclo();
    ciclo();
    n_total++; if (estado !== 2'd0) $display("FAIL t2_inativo_estado: got %0d want 0", estado); else n_pass++;
    n_total++; if (buzzer !== 1'b0) $display("FAIL t2_inativo_buzzer: got %b want 0", buzzer); else n_pass++;
    alarme_ativo = 1'b1;
    disparar();
    n_total++; if (estado !== 2'd1) $display("FAIL t2_disparo: got %0d want 1", estado); else n_pass++;
    // Match held through the ringing: no restart, so the 4th tick still ends it.
    for (int i = 0; i < 3; i++) pulso_tick();
    n_total++; if (estado !== 2'd1) $display("FAIL t2_3ticks: got %0d want 1", estado); else n_pass++;
    pulso_tick();
    n_total++; if (estado !== 2'd0) $display("FAIL t2_fim: got %0d want 0", estado); else n_pass++;
    for (int i = 0; i < 3; i++) pulso_tick();
    n_total++; if (estado !== 2'd0) $display("FAIL t2_sem_novo: got %0d want 0", estado); else n_pass++;
  endtask

  task automatic test_soneca();
    disparar();
    n_total++; if (estado !== 2'd1) $display("FAIL t3_disparo: got %0d want 1", estado); else n_pass++;
    btn_soneca = 1'b1;
    ciclo();
    n_total++; if (estado !== 2'd2) $display("FAIL t3_son1_estado: got %0d want 2", estado); else n_pass++;
    n_total++; if (sonecas_usadas !== 2'd1) $display("FAIL t3_son1_cnt: got %0d want 1", sonecas_usadas); else n_pass++;
    btn_soneca = 1'b0;
    ciclo();
    n_total++; if (buzzer !== 1'b0) $display("FAIL t3_son1_buzzer: got %b want 0", buzzer); else n_pass++;
    n_total++; if (led_alarme !== 1'b1) $display("FAIL t3_son1_led: got %b want 1", led_alarme); else n_pass++;
    pulso_tick();
    pulso_tick();
    n_total++; if (estado !== 2'd2) $display("FAIL t3_son1_2ticks: got %0d want 2", estado); else n_pass++;
    pulso_tick();
    n_total++; if (estado !== 2'd1) $display("FAIL t3_volta1: got %0d want 1", estado); else n_pass++;
    n_total++; if (sonecas_usadas !== 2'd1) $display("FAIL t3_volta1_cnt: got %0d want 1", sonecas_usadas); else n_pass++;
    ciclo();
    n_total++; if (buzzer !== 1'b1) $display("FAIL t3_volta1_buzzer: got %b want 1", buzzer); else n_pass++;
    btn_soneca = 1'b1;
    ciclo();
    btn_soneca = 1'b0;
    n_total++; if (sonecas_usadas !== 2'd2) $display("FAIL t3_son2_cnt: got %0d want 2", sonecas_usadas); else n_pass++;
    for (int i = 0; i < 3; i++) pulso_tick();
    n_total++; if (estado !== 2'd1) $display("FAIL t3_volta2: got %0d want 1", estado); else n_pass++;
    btn_soneca = 1'b1;
    ciclo();
    btn_soneca = 1'b0;
    n_total++; if (estado !== 2'd1) $display("FAIL t3_son3_ignorada: got %0d want 1", estado); else n_pass++;
    n_total++; if (sonecas_usadas !== 2'd2) $display("FAIL t3_son3_cnt: got %0d want 2", sonecas_usadas); else n_pass++;
    btn_parar = 1'b1;
    ciclo();
    btn_parar = 1'b0;
    n_total++; if (estado !== 2'd0) $display("FAIL t3_parar: got %0d want 0", estado); else n_pass++;
    ciclo();
  endtask

  task automatic test_parar_simultaneo();
    disparar();
    btn_soneca = 1'b1;
    ciclo();
    btn_soneca = 1'b0;
    for (int i = 0; i < 3; i++) pulso_tick();
    n_total++; if (estado !== 2'd1) $display("FAIL t4_tocando: got %0d want 1", estado); else n_pass++;
    btn_soneca = 1'b1;
    btn_parar  = 1'b1;
    ciclo();
    btn_soneca = 1'b0;
    n_total++; if (estado !== 2'd0) $display("FAIL t4_parar_vence: got %0d want 0", estado); else n_pass++;
    n_total++; if (sonecas_usadas !== 2'd1) $display("FAIL t4_sonecas: got %0d want 1", sonecas_usadas); else n_pass++;
    // Stop still held: a new event must start and keep ringing.
    ciclo();
    disparar();
    ciclo();
    ciclo();
    n_total++; if (estado !== 2'd1) $display("FAIL t4_parar_segurado: got %0d want 1", estado); else n_pass++;
    btn_parar = 1'b0;
    ciclo();
    btn_parar = 1'b1;
    ciclo();
    btn_parar = 1'b0;
    n_total++; if (estado !== 2'd0) $display("FAIL t4_parar2: got %0d want 0", estado); else n_pass++;
    ciclo();
  endtask

  task automatic test_tick_com_soneca();
    disparar();
    btn_soneca = 1'b1;
    tick_1hz   = 1'b1;
    ciclo();
    btn_soneca = 1'b0;
    tick_1hz   = 1'b0;
    n_total++; if (estado !== 2'd2) $display("FAIL t5_soneca: got %0d want 2", estado); else n_pass++;
    // Full 3-tick snooze proves the coincident tick was dropped.
    pulso_tick();
    pulso_tick();
    n_total++; if (estado !== 2'd2) $display("FAIL t5_2ticks: got %0d want 2", estado); else n_pass++;
    pulso_tick();
    n_total++; if (estado !== 2'd1) $display("FAIL t5_3ticks: got %0d want 1", estado); else n_pass++;
    btn_parar = 1'b1;
    ciclo();
    btn_parar = 1'b0;
    ciclo();
  endtask

  task automatic test_reset_e_desativar();
    disparar();
    btn_soneca = 1'b1;
    ciclo();
    btn_soneca = 1'b0;
    ciclo();
    n_total++; if (estado !== 2'd2) $display("FAIL t6_soneca: got %0d want 2", estado); else n_pass++;
    resetar    = 1'b1;
    hora_atual = empacotar_tempo(8'h00, 8'h00, 8'h00);
    ciclo();
    resetar = 1'b0;
    n_total++; if (estado !== 2'd0) $display("FAIL t6_rst_son_estado: got %0d want 0", estado); else n_pass++;
    n_total++; if (led_alarme !== 1'b0) $display("FAIL t6_rst_son_led: got %b want 0", led_alarme); else n_pass++;
    n_total++; if (sonecas_usadas !== 2'd0) $display("FAIL t6_rst_son_cnt: got %0d want 0", sonecas_usadas); else n_pass++;
    disparar();
    ciclo();
    n_total++; if (buzzer !== 1'b1) $display("FAIL t6_toc_buzzer: got %b want 1", buzzer); else n_pass++;
    resetar    = 1'b1;
    hora_atual = empacotar_tempo(8'h00, 8'h00, 8'h00);
    ciclo();
    resetar = 1'b0;
    n_total++; if (estado !== 2'd0) $display("FAIL t6_rst_toc_estado: got %0d want 0", estado); else n_pass++;
    n_total++; if (buzzer !== 1'b0) $display("FAIL t6_rst_toc_buzzer: got %b want 0", buzzer); else n_pass++;
    n_total++; if (led_alarme !== 1'b0) $display("FAIL t6_rst_toc_led: got %b want 0", led_alarme); else n_pass++;
    ciclo();
    disparar();
    ciclo();
    alarme_ativo = 1'b0;
    ciclo();
    n_total++; if (estado !== 2'd0) $display("FAIL t6_desativar: got %0d want 0", estado); else n_pass++;
    ciclo();
    n_total++; if (buzzer !== 1'b0) $display("FAIL t6_desat_buzzer: got %b want 0", buzzer); else n_pass++;
    n_total++; if (led_alarme !== 1'b0) $display("FAIL t6_desat_led: got %b want 0", led_alarme); else n_pass++;
    alarme_ativo = 1'b1;
  endtask

  initial begin
    resetar         = 1'b1;
    tick_1hz        = 1'b0;
    hora_atual      = '0;
    alarme_completo = empacotar_tempo(8'h07, 8'h00, 8'h00);
    alarme_ativo    = 1'b1;
    btn_soneca      = 1'b0;
    btn_parar       = 1'b0;

    test_reset();
    test_disparo_basico();
    test_inativo_e_unico();
    test_soneca();
    test_parar_simultaneo();
    test_tick_com_soneca();
    test_reset_e_desativar();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
